ro_puf_engine: RTL and testbench
================================

Name: ro_puf_engine

Overview:
Parametrised ring-oscillator PUF measurement engine that turns one challenge into a RESP_BITS-wide response.
- Per response bit: selects an oscillator pair from an external bank of N_OSC free-running ROs, enables only that pair, counts rising edges of both for a programmable window of clk cycles, and compares the counts.
- Sits between the RO bank and the chip I/O wrapper.
- Adds over the previous generation: a clk-domain windowed measurement, multi-bit responses, valid/ready handshake, pair-gated enables, and tie/saturation flags.

Parameters:
N_OSC, 16, number of oscillators in the bank (power of 2, >=4)
SEL_W, 4, log2(N_OSC), challenge seed width
CNT_W, 16, edge-counter width
WIN_W, 16, measurement-window length register width
RESP_BITS, 8, response bits produced per challenge

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-high
osc_in  in  N_OSC  raw oscillator outputs (asynchronous to clk)
osc_en  out  N_OSC  per-oscillator enable to the RO bank
ch_valid  in  1  challenge valid
ch_ready  out  1  engine idle, can accept a challenge
ch_seed  in  SEL_W  challenge seed
win_len  in  WIN_W  window length in clk cycles, sampled on accept
resp  out  RESP_BITS  response word
resp_valid  out  1  one-cycle pulse, resp/flags updated
tie_flag  out  1  at least one bit had cnt_a == cnt_b
sat_flag  out  1  at least one counter saturated
busy  out  1  FSM not in IDLE

Behaviour:
- Reset while rst_n=1, any state: state=IDLE, counters=0, resp=0, flags=0, resp_valid=0, osc_en=0, ch_ready=1, busy=0. A challenge in flight is discarded with no resp_valid.
- Accept: ch_valid & ch_ready on a clk edge. Latch seed and win_len (win_len==0 is treated as 1), set k=0, clear resp/tie/sat, go to ARM.
- ch_ready = (state==IDLE). ch_valid while busy is ignored.
- Pair for bit k: a = (seed+k) mod N_OSC, b = (seed+k+N_OSC/2) mod N_OSC.
- osc_en = onehot(a) | onehot(b) in ARM and MEASURE; 0 in all other states.
- Sampling: every osc_in bit passes a 2-flop synchronizer plus an edge flop. edge = s2 & ~s3. Sync runs continuously and is not reset-gated beyond async clear.
- FSM:
  - IDLE: wait for accept, then ARM.
  - ARM (1 cycle): cnt_a=cnt_b=0, load win counter. Then MEASURE.
  - MEASURE (win_len cycles): cnt_a += edge[a], cnt_b += edge[b], each saturating at 2^CNT_W-1; saturation sets sat_flag. Then COMPARE.
  - COMPARE (1 cycle): resp[k] = (cnt_a > cnt_b); if equal, bit=0 and tie_flag set. If k==RESP_BITS-1 go to DONE, else k++ and go to ARM.
  - DONE (1 cycle): resp_valid=1, then IDLE.
- Latency from accept edge to resp_valid high: RESP_BITS*(win_len+2)+1 cycles.
- resp, tie_flag and sat_flag hold until the next accept.
- Bits are packed LSB-first (bit 0 = first pair measured).
- Oscillator half-period must be >= 2 clk periods; faster inputs alias. This is a documented constraint, not detected.

Decomposition:
- Package ro_puf_pkg: FSM state enum (IDLE, ARM, MEASURE, COMPARE, DONE), pair-index function, saturating-increment function.
- Sub-module ro_edge_sync: N_OSC-wide synchronizer + rising-edge detector, output edge[N_OSC].

Test Plan:
- Latency/handshake: osc_in[0..7] period 4 clk, osc_in[8..15] period 6, seed=0, win_len=100 -> resp=0xFF, tie=0, sat=0; resp_valid exactly 817 cycles after accept; ch_ready=0 throughout.
- Reverse pair: same stimulus, seed=8 -> resp=0x00, tie=0; osc_en during bit 0 = 0x0101.
- Tie: all osc periods 4, seed=3, win_len=40 -> resp=0x00, tie_flag=1.
- Saturation: CNT_W=4, period 4, win_len=100 -> both counts stick at 15, sat_flag=1, tie_flag=1, resp=0x00.
- Reset mid-op: assert rst_n during MEASURE of bit 3 -> next cycle osc_en=0, busy=0, ch_ready=1, resp=0, no resp_valid pulse; a fresh challenge afterwards completes normally.
- Busy drop / win_len=0: ch_valid held with new seed while busy -> ignored; win_len=0 -> 1-cycle windows, resp_valid at RESP_BITS*3+1=25 cycles.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF engine.
// Widths above 32 bits are not supported by the helper functions.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        MEASURE,
        COMPARE,
        DONE
    } state_t;

    // Oscillator index for a pair member; n is a power of two, so wrap is a mask.
    function automatic logic [31:0] pair_idx(input logic [31:0] seed,
                                             input logic [31:0] k,
                                             input logic [31:0] off,
                                             input logic [31:0] n);
        return (seed + k + off) & (n - 32'd1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input logic        inc,
                                            input logic [31:0] maxv);
        return (inc && (v != maxv)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for every oscillator input.
// Runs every cycle; the reset only clears the flops.
module ro_edge_sync #(
    parameter int N_OSC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_OSC-1:0] osc_in,
    output logic [N_OSC-1:0] osc_edge
);

    logic [N_OSC-1:0] s1, s2, s3;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= osc_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign osc_edge = s2 & ~s3;

endmodule

// File: rtl/ro_puf_engine.sv
// RO PUF measurement engine: per response bit, gate one oscillator pair on,
// count both for a window of clk cycles and compare the counts.
module ro_puf_engine
    import ro_puf_pkg::*;
#(
    parameter int N_OSC     = 16,
    parameter int SEL_W     = 4,
    parameter int CNT_W     = 16,
    parameter int WIN_W     = 16,
    parameter int RESP_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_OSC-1:0]     osc_in,
    output logic [N_OSC-1:0]     osc_en,
    input  logic                 ch_valid,
    output logic                 ch_ready,
    input  logic [SEL_W-1:0]     ch_seed,
    input  logic [WIN_W-1:0]     win_len,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    output logic                 tie_flag,
    output logic                 sat_flag,
    output logic                 busy
);

    localparam int K_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t               state, state_nx;
    logic [SEL_W-1:0]     seed_q;
    logic [WIN_W-1:0]     win_q, win_cnt;
    logic [K_W-1:0]       k_q;
    logic [CNT_W-1:0]     cnt_a, cnt_b, nxt_a, nxt_b;
    logic [RESP_BITS-1:0] resp_q;
    logic                 tie_q, sat_q, rv_q;
    logic [SEL_W-1:0]     idx_a, idx_b;
    logic [N_OSC-1:0]     osc_edge;

    ro_edge_sync #(.N_OSC(N_OSC)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .osc_in   (osc_in),
        .osc_edge (osc_edge)
    );

    assign idx_a = SEL_W'(pair_idx(32'(seed_q), 32'(k_q), 32'd0, 32'(N_OSC)));
    assign idx_b = SEL_W'(pair_idx(32'(seed_q), 32'(k_q), 32'(N_OSC / 2), 32'(N_OSC)));
    assign nxt_a = CNT_W'(sat_inc(32'(cnt_a), osc_edge[idx_a], 32'(CNT_MAX)));
    assign nxt_b = CNT_W'(sat_inc(32'(cnt_b), osc_edge[idx_b], 32'(CNT_MAX)));

    always_comb begin
        osc_en = '0;
        if (state == ARM || state == MEASURE) begin
            osc_en[idx_a] = 1'b1;
            osc_en[idx_b] = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ch_valid) state_nx = ARM;
            ARM:     state_nx = MEASURE;
            MEASURE: if (win_cnt == WIN_W'(1)) state_nx = COMPARE;
            COMPARE: state_nx = (k_q == K_W'(RESP_BITS - 1)) ? DONE : ARM;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state   <= IDLE;
            seed_q  <= '0;
            win_q   <= '0;
            win_cnt <= '0;
            k_q     <= '0;
            cnt_a   <= '0;
            cnt_b   <= '0;
            resp_q  <= '0;
            tie_q   <= 1'b0;
            sat_q   <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state <= state_nx;
            rv_q  <= (state == DONE);
            case (state)
                IDLE: if (ch_valid) begin
                    seed_q <= ch_seed;
                    // A zero-length window would never count; run it as one cycle.
                    win_q  <= (win_len == '0) ? WIN_W'(1) : win_len;
                    k_q    <= '0;
                    resp_q <= '0;
                    tie_q  <= 1'b0;
                    sat_q  <= 1'b0;
                end
                ARM: begin
                    cnt_a   <= '0;
                    cnt_b   <= '0;
                    win_cnt <= win_q;
                end
                MEASURE: begin
                    cnt_a   <= nxt_a;
                    cnt_b   <= nxt_b;
                    win_cnt <= win_cnt - WIN_W'(1);
                    if (nxt_a == CNT_MAX || nxt_b == CNT_MAX) sat_q <= 1'b1;
                end
                COMPARE: begin
                    resp_q[k_q] <= (cnt_a > cnt_b);
                    if (cnt_a == cnt_b) tie_q <= 1'b1;
                    if (k_q != K_W'(RESP_BITS - 1)) k_q <= k_q + K_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign ch_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp       = resp_q;
    assign tie_flag   = tie_q;
    assign sat_flag   = sat_q;
    assign resp_valid = rv_q;

endmodule

// File: tb/tb_ro_puf_engine.sv
// Bench for ro_puf_engine: two instances (16-bit and 4-bit counters) against a
// model that counts sampled rising edges over each window directly.
module tb_ro_puf_engine;

    localparam int N = 16;
    localparam int RB = 8;
    localparam int HMAX = 100000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] osc_in = '0;
    logic        ch_valid = 1'b0;
    logic [3:0]  ch_seed = '0;
    logic [15:0] win_len = '0;

    logic [15:0] en_a, en_b;
    logic        rdy_a, rdy_b, rv_a, rv_b, tie_a, tie_b, sat_a, sat_b, busy_a, busy_b;
    logic [7:0]  resp_a, resp_b;

    ro_puf_engine #(.N_OSC(16), .SEL_W(4), .CNT_W(16), .WIN_W(16), .RESP_BITS(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .osc_en(en_a), .ch_valid(ch_valid),
        .ch_ready(rdy_a), .ch_seed(ch_seed), .win_len(win_len), .resp(resp_a),
        .resp_valid(rv_a), .tie_flag(tie_a), .sat_flag(sat_a), .busy(busy_a));

    ro_puf_engine #(.N_OSC(16), .SEL_W(4), .CNT_W(4), .WIN_W(16), .RESP_BITS(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .osc_en(en_b), .ch_valid(ch_valid),
        .ch_ready(rdy_b), .ch_seed(ch_seed), .win_len(win_len), .resp(resp_b),
        .resp_valid(rv_b), .tie_flag(tie_b), .sat_flag(sat_b), .busy(busy_b));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Free-running square waves, period/phase chosen by the stimulus.
    int per[16] = '{default: 4};
    int ph[16]  = '{default: 0};
    int ncyc = 0;
    always @(negedge clk) begin
        ncyc++;
        for (int i = 0; i < N; i++) osc_in[i] = (((ncyc + ph[i]) % per[i]) < (per[i] / 2));
    end

    // Model: osc value sampled at each edge, plus the accepted challenge.
    logic [15:0] hist [0:HMAX-1];
    int ecount = 0;
    int acc = -1, m_w = 1, m_seed = 0;

    always @(posedge clk) begin
        if (ecount < HMAX) hist[ecount] = rst_n ? 16'h0 : osc_in;
        if (rst_n) acc = -1;
        else if (ch_valid && (acc < 0 || ecount - acc >= RB * (m_w + 2) + 2)) begin
            acc    = ecount;
            m_w    = (win_len == 0) ? 1 : int'(win_len);
            m_seed = int'(ch_seed);
        end
        ecount++;
    end

    task automatic model(input int maxc, output logic [7:0] r, output logic ti, output logic sa);
        int a, b, ca, cb, e;
        r = '0; ti = 1'b0; sa = 1'b0;
        for (int k = 0; k < RB; k++) begin
            a = (m_seed + k) % N;
            b = (m_seed + k + N / 2) % N;
            ca = 0; cb = 0;
            for (int j = 1; j <= m_w; j++) begin
                e = acc + k * (m_w + 2) + j;
                if (e >= 2) begin
                    ca += int'(hist[e-1][a] & ~hist[e-2][a]);
                    cb += int'(hist[e-1][b] & ~hist[e-2][b]);
                end
            end
            if (ca > maxc) ca = maxc;
            if (cb > maxc) cb = maxc;
            r[k] = (ca > cb);
            if (ca == cb) ti = 1'b1;
            if (ca == maxc || cb == maxc) sa = 1'b1;
        end
    endtask

    logic [7:0] h_r[2];
    logic       h_t[2], h_s[2];
    initial begin
        h_r[0] = 0; h_r[1] = 0; h_t[0] = 0; h_t[1] = 0; h_s[0] = 0; h_s[1] = 0;
    end

    always @(negedge clk) begin : compare
        int e, t, len, k, j;
        logic [15:0] x_en;
        logic x_busy, x_rdy, x_rv, ck_res, ck_zero;
        if (ecount > 0) begin
            e = ecount - 1;
            len = RB * (m_w + 2);
            t = (acc >= 0) ? e - acc : -1;
            x_en = '0; x_busy = 0; x_rdy = 1; x_rv = 0; ck_res = 0; ck_zero = 0;
            if (rst_n) begin
                for (int d = 0; d < 2; d++) begin h_r[d] = 0; h_t[d] = 0; h_s[d] = 0; end
                ck_res = 1;
            end else if (t >= 0 && t < len) begin
                k = t / (m_w + 2);
                j = t % (m_w + 2);
                x_busy = 1; x_rdy = 0;
                if (j <= m_w)
                    x_en = (16'h1 << ((m_seed + k) % N)) | (16'h1 << ((m_seed + k + N / 2) % N));
                ck_zero = (t <= m_w + 1);
            end else if (t == len) begin
                x_busy = 1; x_rdy = 0;
            end else begin
                if (t == len + 1) begin
                    model(65535, h_r[0], h_t[0], h_s[0]);
                    model(15, h_r[1], h_t[1], h_s[1]);
                    x_rv = 1;
                end
                ck_res = 1;
            end
            chk("osc_en_16", en_a, x_en);     chk("osc_en_4", en_b, x_en);
            chk("busy_16", busy_a, x_busy);   chk("busy_4", busy_b, x_busy);
            chk("ready_16", rdy_a, x_rdy);    chk("ready_4", rdy_b, x_rdy);
            chk("rvalid_16", rv_a, x_rv);     chk("rvalid_4", rv_b, x_rv);
            if (ck_res) begin
                chk("resp_16", resp_a, h_r[0]); chk("resp_4", resp_b, h_r[1]);
                chk("tie_16", tie_a, h_t[0]);   chk("tie_4", tie_b, h_t[1]);
                chk("sat_16", sat_a, h_s[0]);   chk("sat_4", sat_b, h_s[1]);
            end
            if (ck_zero) begin
                chk("resp_clr_16", resp_a, 0); chk("resp_clr_4", resp_b, 0);
            end
        end
    end

    task automatic run_op(input int s, input int w, input int jam,
                          output int lat, output logic [15:0] en0);
        @(negedge clk);
        ch_valid = 1; ch_seed = 4'(s); win_len = 16'(w);
        @(negedge clk);
        ch_valid = 0; en0 = en_a; lat = 0;
        while (!rv_a && lat < 20000) begin
            @(negedge clk);
            lat++;
            if (lat == jam) begin ch_valid = 1; ch_seed = ~ch_seed; end
            if (lat == jam + 10) ch_valid = 0;
        end
        if (lat >= 20000) chk("rvalid_timeout", rv_a, 1);
    endtask

    initial begin
        int lat, s, w;
        logic [15:0] en0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp", resp_a, 0); chk("rst_ready", rdy_a, 1);
        chk("rst_busy", busy_a, 0); chk("rst_osc_en", en_a, 0);
        @(posedge clk); #2 rst_n = 0;
        repeat (4) @(posedge clk);

        // Fast half of the bank against the slow half, then reversed.
        for (int i = 0; i < N; i++) begin per[i] = (i < 8) ? 4 : 6; ph[i] = 0; end
        run_op(0, 100, -1, lat, en0);
        chk("lat_817", lat, 817); chk("resp_ff", resp_a, 8'hFF);
        chk("tie_0", tie_a, 0); chk("sat_0", sat_a, 0);
        run_op(8, 100, -1, lat, en0);
        chk("bit0_osc_en", en0, 16'h0101); chk("resp_00", resp_a, 8'h00); chk("tie_rev", tie_a, 0);

        // Identical waves: ties everywhere; the 4-bit counters also saturate.
        for (int i = 0; i < N; i++) begin per[i] = 4; ph[i] = 0; end
        run_op(3, 40, -1, lat, en0);
        chk("tie_resp", resp_a, 8'h00); chk("tie_flag", tie_a, 1);
        run_op(0, 100, -1, lat, en0);
        chk("sat_resp4", resp_b, 8'h00); chk("sat_flag4", sat_b, 1);
        chk("sat_tie4", tie_b, 1); chk("nosat_16", sat_a, 0);

        // Reset during the bit-3 window, then a clean challenge.
        for (int i = 0; i < N; i++) begin per[i] = (i < 8) ? 4 : 6; ph[i] = i % 3; end
        @(negedge clk); ch_valid = 1; ch_seed = 0; win_len = 20;
        @(negedge clk); ch_valid = 0;
        repeat (3 * 22 + 5) @(negedge clk);
        @(posedge clk); #2 rst_n = 1;
        @(negedge clk);
        chk("mid_rst_osc_en", en_a, 0); chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_ready", rdy_a, 1); chk("mid_rst_resp", resp_a, 0);
        repeat (3) @(posedge clk); #2 rst_n = 0;
        run_op(2, 30, -1, lat, en0);
        chk("post_rst_lat", lat, RB * 32 + 1);

        // Challenges presented while busy are dropped; zero window acts as one.
        run_op(5, 10, 20, lat, en0);
        chk("busy_drop_lat", lat, 97);
        run_op(1, 0, -1, lat, en0);
        chk("win0_lat", lat, 25);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) begin
                per[i] = int'($urandom_range(4, 11));
                ph[i]  = int'($urandom_range(0, per[i] - 1));
            end
            s = int'($urandom_range(0, 15));
            w = int'($urandom_range(0, 40));
            run_op(s, w, -1, lat, en0);
            chk("rand_lat", lat, RB * (((w == 0) ? 1 : w) + 2) + 1);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
